// File: rtl/ifetch.sv
// rtl/ifetch.sv - PC, req/ack instruction fetch and decode FIFO feeding ctrl
// Optional misaligned-redirect trap/halt: define IFETCH_MISALIGN_TRAP_EN.
module ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        PCSrc_i,
    input  logic [31:0] pc_target_i,
    input  logic        dec_ready_i,
    output logic        dec_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic [6:0]  op_o,
    output logic [2:0]  funct3_o,
    output logic        funct7_o,
    output logic        misalign_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DROP} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   drop_pc_q, drop_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic          misalign_q, misalign_d;
    logic [31:0]   instr_mem [FIFO_DEPTH];
    logic [31:0]   pc_mem    [FIFO_DEPTH];
    logic          push, pop, halted;
    logic [31:0]   redirect_pc;

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign redirect_pc = pc_target_i;
    assign misalign_d  = misalign_q | (PCSrc_i & (pc_target_i[1:0] != 2'b00));
`else
    assign redirect_pc = pc_target_i & 32'hFFFF_FFFC;
    assign misalign_d  = 1'b0;
`endif
    assign halted = misalign_q;

    // A redirect wins over both the response and the consumer in the same cycle.
    assign push = (state_q == S_BUSY) && imem_ack_i && !PCSrc_i;
    assign pop  = dec_valid_o && dec_ready_i && !PCSrc_i;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_pc_d  = drop_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (PCSrc_i) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = redirect_pc;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + AW'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
        case (state_q)
            S_IDLE: begin
                if (!PCSrc_i && !halted && (count_q < DEPTH_C)) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (PCSrc_i) begin
                    if (imem_ack_i) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DROP;
                        drop_pc_d = fetch_pc_q;
                    end
                end else if (imem_ack_i) begin
                    state_d = (count_d < DEPTH_C) ? S_BUSY : S_IDLE;
                end
            end
            S_DROP: begin
                if (imem_ack_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            drop_pc_q  <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_pc_q  <= drop_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            misalign_q <= misalign_d;
        end
    end

    // Storage needs no reset: reads are masked by dec_valid_o.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata_i;
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
        end
    end

    assign imem_req_o  = (state_q != S_IDLE);
    assign imem_addr_o = (state_q == S_DROP) ? drop_pc_q : fetch_pc_q;
    assign dec_valid_o = (count_q != '0);
    assign instr_o     = dec_valid_o ? instr_mem[rd_ptr_q] : 32'h0;
    assign instr_pc_o  = dec_valid_o ? pc_mem[rd_ptr_q] : 32'h0;
    assign op_o        = instr_o[6:0];
    assign funct3_o    = instr_o[14:12];
    assign funct7_o    = instr_o[30];
    assign misalign_o  = misalign_q;
endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - self-checking bench for ifetch: vector table, corner sequences, random stream model
module tb_ifetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        pcsrc;
    logic [31:0] pc_target;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    ifetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
        .PCSrc_i(pcsrc), .pc_target_i(pc_target),
        .dec_ready_i(dec_ready), .dec_valid_o(dec_valid),
        .instr_o(instr), .instr_pc_o(instr_pc),
        .op_o(op), .funct3_o(funct3), .funct7_o(funct7),
        .misalign_o(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        pcsrc;
        logic [31:0] target;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a | 32'h13;
    endfunction

    task automatic chk_head(input string tag, input logic [31:0] e_pc, input logic [31:0] e);
        chk({tag, " instr_pc"}, instr_pc, e_pc);
        chk({tag, " instr"}, instr, e);
        chk({tag, " op"}, 32'(op), 32'(e[6:0]));
        chk({tag, " funct3"}, 32'(funct3), 32'(e[14:12]));
        chk({tag, " funct7"}, 32'(funct7), 32'(e[30]));
    endtask

    logic        prev_req, prev_ack, prev_pcsrc;
    logic [31:0] prev_addr, exp_pc, a_tgt, e;
    logic        a_ack, a_ready, a_pcsrc;
    int          delivered;

    initial begin
        // {rst, ack, rdata, pcsrc, target, ready, e_req, e_addr, e_valid, e_pc, e_instr}
        vecs[0]  = '{0, 0, 32'h0,         0, 32'h0,   1, 0, 32'h0,   0, 32'h0,   32'h0};
        vecs[1]  = '{0, 1, 32'h13,        0, 32'h0,   1, 1, 32'h0,   0, 32'h0,   32'h0};
        vecs[2]  = '{0, 1, 32'h17,        0, 32'h0,   1, 1, 32'h4,   1, 32'h0,   32'h13};
        vecs[3]  = '{0, 1, 32'h1B,        0, 32'h0,   1, 1, 32'h8,   1, 32'h4,   32'h17};
        vecs[4]  = '{1, 0, 32'h0,         0, 32'h0,   0, 1, 32'hC,   1, 32'h8,   32'h1B};
        vecs[5]  = '{0, 0, 32'h0,         0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   32'h0};
        vecs[6]  = '{0, 1, 32'h13,        0, 32'h0,   0, 1, 32'h0,   0, 32'h0,   32'h0};
        vecs[7]  = '{0, 1, 32'h17,        0, 32'h0,   0, 1, 32'h4,   1, 32'h0,   32'h13};
        vecs[8]  = '{0, 0, 32'h0,         0, 32'h0,   0, 0, 32'h0,   1, 32'h0,   32'h13};
        vecs[9]  = '{0, 0, 32'h0,         0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   32'h13};
        vecs[10] = '{0, 0, 32'h0,         0, 32'h0,   1, 0, 32'h0,   1, 32'h4,   32'h17};
        vecs[11] = '{0, 0, 32'h0,         1, 32'h100, 1, 1, 32'h8,   0, 32'h0,   32'h0};
        vecs[12] = '{0, 0, 32'h0,         0, 32'h0,   1, 1, 32'h8,   0, 32'h0,   32'h0};
        vecs[13] = '{0, 1, 32'hDEAD_0013, 0, 32'h0,   1, 1, 32'h8,   0, 32'h0,   32'h0};
        vecs[14] = '{0, 0, 32'h0,         0, 32'h0,   1, 0, 32'h0,   0, 32'h0,   32'h0};
        vecs[15] = '{0, 1, 32'h113,       0, 32'h0,   1, 1, 32'h100, 0, 32'h0,   32'h0};
        vecs[16] = '{0, 1, 32'h117,       1, 32'h200, 1, 1, 32'h104, 1, 32'h100, 32'h113};
        vecs[17] = '{0, 0, 32'h0,         0, 32'h0,   1, 0, 32'h0,   0, 32'h0,   32'h0};
        vecs[18] = '{0, 1, 32'h213,       0, 32'h0,   1, 1, 32'h200, 0, 32'h0,   32'h0};
        vecs[19] = '{0, 0, 32'h0,         0, 32'h0,   1, 1, 32'h204, 1, 32'h200, 32'h213};
        vecs[20] = '{0, 0, 32'h0,         0, 32'h0,   0, 1, 32'h204, 0, 32'h0,   32'h0};

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; pcsrc = 1'b0;
        pc_target = 32'h0; dec_ready = 1'b0;
        tick();
        tick();
        chk("reset misalign", 32'(misalign), 32'h0);

        for (int i = 0; i < NV; i++) begin
            chk($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req)
                chk($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("row%0d dec_valid", i), 32'(dec_valid), 32'(vecs[i].e_valid));
            chk_head($sformatf("row%0d", i), vecs[i].e_pc, vecs[i].e_instr);
            rst = vecs[i].rst; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
            pcsrc = vecs[i].pcsrc; pc_target = vecs[i].target; dec_ready = vecs[i].ready;
            tick();
        end

        // Reset mid-fetch with a non-empty FIFO, then a late ack while IDLE.
        imem_ack = 1'b1; imem_rdata = 32'h217;
        tick();
        chk("pre-reset dec_valid", 32'(dec_valid), 32'h1);
        chk_head("pre-reset", 32'h204, 32'h217);
        imem_ack = 1'b0;
        rst = 1'b1;
        #1;
        chk("async reset imem_req", 32'(imem_req), 32'h0);
        chk("async reset dec_valid", 32'(dec_valid), 32'h0);
        chk_head("async reset", 32'h0, 32'h0);
        tick();
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0013;
        tick();
        chk("restart imem_req", 32'(imem_req), 32'h1);
        chk("restart imem_addr", imem_addr, 32'h0);
        chk("late ack ignored", 32'(dec_valid), 32'h0);
        imem_ack = 1'b0;
        tick();
        chk("restart hold imem_addr", imem_addr, 32'h0);
        chk("restart hold dec_valid", 32'(dec_valid), 32'h0);

        // Random stream against an in-order address model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        prev_req = 1'b0; prev_ack = 1'b0; prev_pcsrc = 1'b0; prev_addr = 32'h0;
        exp_pc = 32'h0; delivered = 0;
        for (int c = 0; c < 2000; c++) begin
            if (prev_req && !prev_ack) begin
                chk("rand req held", 32'(imem_req), 32'h1);
                chk("rand addr held", imem_addr, prev_addr);
            end
            if (prev_pcsrc)
                chk("rand flush", 32'(dec_valid), 32'h0);
            a_ack   = imem_req && ($urandom_range(0, 2) != 0);
            a_ready = 1'($urandom_range(0, 1));
            a_pcsrc = ($urandom_range(0, 24) == 0);
            a_tgt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 1023)) << 2);
`ifndef IFETCH_MISALIGN_TRAP_EN
            a_tgt   = a_tgt | 32'($urandom_range(0, 3));
`endif
            if (dec_valid && a_ready && !a_pcsrc) begin
                e = memfn(exp_pc);
                chk_head("rand pop", exp_pc, e);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (a_pcsrc)
                exp_pc = a_tgt & 32'hFFFF_FFFC;
            imem_ack   = a_ack;
            imem_rdata = a_ack ? memfn(imem_addr) : $urandom;
            dec_ready  = a_ready;
            pcsrc      = a_pcsrc;
            pc_target  = a_tgt;
            prev_req   = imem_req;
            prev_addr  = imem_addr;
            prev_ack   = a_ack;
            prev_pcsrc = a_pcsrc;
            tick();
        end
        pcsrc = 1'b0; imem_ack = 1'b0; dec_ready = 1'b0;
        chk("rand liveness", (delivered > 200) ? 32'h1 : 32'h0, 32'h1);

        // Misaligned redirect while a fetch is outstanding.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        pcsrc = 1'b1; pc_target = 32'h102;
        tick();
        pcsrc = 1'b0;
        chk("misalign drop imem_req", 32'(imem_req), 32'h1);
        chk("misalign drop imem_addr", imem_addr, 32'h0);
        chk("misalign drop dec_valid", 32'(dec_valid), 32'h0);
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk("misalign flag", 32'(misalign), 32'h1);
`else
        chk("misalign flag", 32'(misalign), 32'h0);
`endif
        imem_ack = 1'b1; imem_rdata = 32'h13;
        tick();
        imem_ack = 1'b0;
        chk("misalign drained imem_req", 32'(imem_req), 32'h0);
        tick();
`ifdef IFETCH_MISALIGN_TRAP_EN
        for (int k = 0; k < 5; k++) begin
            chk("halted imem_req", 32'(imem_req), 32'h0);
            chk("halted misalign", 32'(misalign), 32'h1);
            tick();
        end
`else
        chk("aligned resume imem_req", 32'(imem_req), 32'h1);
        chk("aligned resume imem_addr", imem_addr, 32'h100);
        imem_ack = 1'b1; imem_rdata = 32'h113;
        tick();
        imem_ack = 1'b0;
        chk("aligned resume dec_valid", 32'(dec_valid), 32'h1);
        chk_head("aligned resume", 32'h100, 32'h113);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch stage directly upstream of `ctrl`. Holds the program counter, fetches 32-bit instructions over a req/ack instruction-memory port into a small FIFO, and presents the head instruction with its `op`/`funct3`/`funct7` fields to `ctrl` under a valid/ready handshake. A taken redirect (`PCSrc`, with its target) flushes the FIFO, squashes any in-flight fetch and restarts fetching at the target.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `FIFO_DEPTH`, 2: instruction buffer entries; power of two, ≥2.
- `clk`  in  1: the single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `imem_req`  out  1: fetch request; `imem_addr` is held stable while high.
- `imem_addr`  out  32: word-aligned fetch address.
- `imem_ack`  in  1: the response is valid this cycle; it may coincide with the first cycle of `imem_req`.
- `imem_rdata`  in  32: instruction word, qualified by `imem_ack`.
- `PCSrc`  in  1: one-cycle redirect pulse.
- `pc_target`  in  32: redirect address, qualified by `PCSrc`.
- `dec_ready`  in  1: downstream accepts the head instruction.
- `dec_valid`  out  1: the FIFO is non-empty.
- `instr`  out  32: head instruction; 0 when `dec_valid`=0.
- `instr_pc`  out  32: address of the head instruction; 0 when `dec_valid`=0.
- `op`  out  7: `instr[6:0]`.
- `funct3`  out  3: `instr[14:12]`.
- `funct7`  out  1: `instr[30]`.
- `misalign`  out  1: sticky misaligned-target flag (see Configuration).

## Operation
- The FSM has three states: IDLE (nothing outstanding), BUSY (`imem_req`=1, waiting for ack) and DROP (`imem_req`=1, completing a squashed fetch).
- `imem_req` = (state != IDLE). `imem_addr` = `fetch_pc` in BUSY, and the squashed address in DROP.
- Space test: `count_next < FIFO_DEPTH`, where `count_next` includes this cycle's push and pop.
- IDLE -> BUSY at the next edge when `count` < `FIFO_DEPTH`, the block is not halted and there is no redirect.
- BUSY with ack and no redirect:
  - Push {`imem_rdata`, `fetch_pc`}.
  - `fetch_pc` += 4, wrapping modulo 2^32.
  - Next state is BUSY if there is space, otherwise IDLE. This gives back-to-back fetches at 1 instruction/cycle.
- Pop when `dec_valid` && `dec_ready` && !`PCSrc`. A push and a pop in the same cycle are both allowed.
- Redirect (`PCSrc`=1) in any state:
  - `count` <- 0 and `fetch_pc` <- `pc_target`.
  - From BUSY with no ack in the same cycle, go to DROP. Otherwise go to IDLE, and any ack data in that cycle is discarded.
- DROP with ack: discard the data and go to IDLE.
- DROP with a further redirect: stay in DROP and update `fetch_pc` to the newest target.
- Overflow cannot occur: a request is issued only when space is guaranteed.

## Timing
- Reset values (asynchronous): state IDLE, `fetch_pc`=`RESET_PC`, `count`=0, `imem_req`=0, `dec_valid`=0, `instr`/`instr_pc`/`op`/`funct3`/`funct7`=0, `misalign`=0.
- First request: `imem_req`=1 with `imem_addr`=`RESET_PC` from the first rising edge after `rst` deasserts.
- Fetch latency: an ack sampled at edge E makes `dec_valid`=1 with that instruction after E. Outputs are registered FIFO state, with no combinational path from `imem_rdata`.
- Redirect at edge E:
  - `dec_valid`=0 after E.
  - With nothing outstanding, `imem_req` is asserted with `imem_addr`=`pc_target` after E+1.
  - From DROP, the target is requested starting one edge after the squashed ack.
- A `PCSrc` arriving in the same cycle as a pop or an ack takes priority: the FIFO is empty afterwards.
- `rst` asserted mid-fetch returns every output to its reset value immediately. Any late `imem_ack` seen while in IDLE is ignored.

## Configuration
- `IFETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `pc_target[1:0]` != 0 sets `misalign`=1 (sticky until `rst`).
  - The FIFO is flushed and no further requests are issued (halted).
  - An outstanding fetch still completes through DROP.
- Not defined: `misalign` is tied to 0. `pc_target[1:0]` is forced to 0 on redirect and fetching continues.

## Test plan
- Reset and stream: `RESET_PC`=0, ack every cycle with data=addr|0x13, `dec_ready`=1.
  - Expect addresses 0, 4, 8 and `instr` 0x13, 0x17, 0x1B on consecutive cycles.
  - Expect `op`=0x13 and `funct3`=0 for the first instruction.
- Backpressure: `dec_ready`=0 and ack every cycle.
  - Expect exactly 2 pushes, then `imem_req`=0 and `count`=2.
  - Raising `dec_ready` pops entries from PC 0, then PC 4, and fetching resumes at 8.
- Redirect while BUSY without ack: `PCSrc`=1, `pc_target`=0x100 while waiting at addr 0x8.
  - Expect DROP with addr 0x8 held.
  - When ack arrives its data is discarded, then `imem_addr`=0x100. The first `dec_valid` shows `instr_pc`=0x100.
- Simultaneous events: `PCSrc`, `imem_ack` and pop all in one cycle.
  - Expect `dec_valid`=0 next cycle and no instruction from the old path ever delivered.
- Reset mid-fetch: assert `rst` while BUSY.
  - Expect `imem_req`=0 and `dec_valid`=0 immediately, then a restart at `RESET_PC`.
- Misaligned target: redirect to 0x102.
  - With the macro defined: `misalign`=1 and no further `imem_req`.
  - Without the macro: fetch resumes at 0x100.
